// File: rtl/hamming_tx_ctrl_pkg.sv
// rtl/hamming_tx_ctrl_pkg.sv - shared widths, frame constants and FSM encoding for the Hamming transmit path
package hamming_tx_ctrl_pkg;

    localparam int DATA_W      = 8;
    localparam int CODE_W      = 12;
    localparam int FRAME_BITS  = 14;
    localparam int INJ_POS_MAX = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/hamming.sv
// rtl/hamming.sv - combinational 8->12 Hamming encoder
// Codeword bit i is Hamming position i+1; parity sits at positions 1,2,4,8.
module hamming
    import hamming_tx_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CODE_W-1:0] code
);

    logic p1, p2, p4, p8;

    assign p1 = data[0] ^ data[1] ^ data[3] ^ data[4] ^ data[6];
    assign p2 = data[0] ^ data[2] ^ data[3] ^ data[5] ^ data[6];
    assign p4 = data[1] ^ data[2] ^ data[3] ^ data[7];
    assign p8 = data[4] ^ data[5] ^ data[6] ^ data[7];

    assign code = {data[7], data[6], data[5], data[4], p8,
                   data[3], data[2], data[1], p4, data[0], p2, p1};

endmodule

// File: rtl/hamming_baud_tick.sv
// rtl/hamming_baud_tick.sv - CLKS_PER_BIT divider with synchronous clear and end-of-bit pulses
module hamming_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic bit_end,
    output logic pre_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign bit_end = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));
    // pre_end flags the cycle before bit_end so the FSM can register frame_done
    assign pre_end = en && (CLKS_PER_BIT > 1) && (cnt == CNT_W'(CLKS_PER_BIT - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || bit_end) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hamming_tx_ctrl.sv
// rtl/hamming_tx_ctrl.sv - byte-in, framed serial Hamming codeword out (start, 12 code bits LSB first, stop)
// Optional HAMMING_ERR_INJECT_EN adds inj_en/inj_pos to flip one codeword bit at load time.
module hamming_tx_ctrl
    import hamming_tx_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic              inj_en,
    input  logic [3:0]        inj_pos,
`endif
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    tx_state_t         state;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] load_code;
    logic [CODE_W-1:0] shift_reg;
    logic [3:0]        bit_cnt;
    logic              accept;
    logic              bit_end;
    logic              pre_end;

    hamming u_enc (
        .data (in_data),
        .code (code)
    );

`ifdef HAMMING_ERR_INJECT_EN
    assign load_code = code ^ ((inj_en && (inj_pos <= 4'(INJ_POS_MAX)))
                               ? (CODE_W'(1) << inj_pos) : '0);
`else
    assign load_code = code;
`endif

    assign accept = (state == IDLE) && in_valid && in_ready;

    hamming_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .en      (state != IDLE),
        .bit_end (bit_end),
        .pre_end (pre_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (accept) begin
                        state     <= START;
                        shift_reg <= load_code;
                        tx        <= 1'b0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        in_ready  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        tx    <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == 4'(CODE_W - 1)) begin
                            bit_cnt    <= '0;
                            state      <= STOP;
                            tx         <= 1'b1;
                            // a one-cycle stop bit is its own last cycle
                            frame_done <= (CLKS_PER_BIT == 1);
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            tx      <= shift_reg[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state      <= IDLE;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b0;
                    end else begin
                        frame_done <= pre_end;
                    end
                end
            endcase
        end
    end

endmodule
